rotary_menu_ctrl: RTL and testbench
===================================

ROTARY_MENU_CTRL -- requirements
Module: rotary_menu_ctrl

Interface
REQ-001 SHALL have parameter SAMPLE_DIV, default 50000: CLK cycles per sample tick (1 kHz at 50 MHz).
REQ-002 SHALL have parameter DEB_CNT, default 4: consecutive differing ticks needed to change a debounced input.
REQ-003 SHALL have parameter LONG_TICKS, default 1000: ticks of center hold that make a long press.
REQ-004 SHALL have parameter WRAP, default 1: 1 = wrap values modulo 16, 0 = saturate at 0/15.
REQ-005 SHALL have port CLK, input, 1: sole clock, rising edge.
REQ-006 SHALL have port RESETN, input, 1: reset, synchronous, active-low.
REQ-007 SHALL have ports ROTA, ROTB, ROTCTR, input, 1 each: raw encoder A, B and center push, asynchronous.
REQ-008 SHALL have port SEL, output, 2: index of the selected parameter.
REQ-009 SHALL have port VALUE, output, 4: value of the selected parameter.
REQ-010 SHALL have port PARAMS, output, 16: param3..param0, 4 bits each, param0 in [3:0].
REQ-011 SHALL have port UPD, output, 1: one-cycle pulse on any change to SEL or PARAMS.
REQ-012 SHALL have port DIR, output, 1: direction of the last accepted step (1 = up).

Function
REQ-013 Each raw input SHALL pass a 2-flop synchronizer before any other use.
REQ-014 The tick counter SHALL count 0..SAMPLE_DIV-1 and assert tick for one cycle when it equals SAMPLE_DIV-1, then return to 0.
REQ-015 Debouncing, per input, on tick only: sample equal to the stable value clears the count; otherwise the count increments; the stable value toggles and the count clears when the count reaches DEB_CNT-1.
REQ-016 A step event SHALL occur in the cycle the debounced A shows 0->1: debounced B = 0 means up (+1); B = 1 means down (-1).
REQ-017 Center FSM states: IDLE, HELD, LONG.
  - IDLE->HELD on debounced CTR rise; the hold counter clears.
  - HELD: the hold counter increments on each tick.
  - HELD->IDLE on CTR fall with hold < LONG_TICKS: short press, SEL <= SEL+1 with 3->0 wrap.
  - HELD->LONG when hold reaches LONG_TICKS: selected parameter <= 0.
  - LONG->IDLE on CTR fall, with no further action.
REQ-018 Step events SHALL be applied only in IDLE; they are discarded in HELD and LONG.
REQ-019 Same-cycle step event and CTR rise: the press is taken and the step is discarded.
REQ-020 Step arithmetic, 4-bit unsigned:
  - WRAP = 1: 15+1 -> 0 and 0-1 -> 15.
  - WRAP = 0: values clamp at 15 and 0; a clamped step leaves the value unchanged, asserts no UPD, but still updates DIR.
REQ-021 Parameter, SEL and DIR registers SHALL update one cycle after the triggering event; UPD SHALL assert in the same cycle the new value is visible.
REQ-022 VALUE SHALL be a combinational select of PARAMS by SEL.
REQ-023 A long-press clear of a parameter already at 0 SHALL NOT assert UPD.

Reset
REQ-024 When RESETN = 0 at a rising CLK edge, all state SHALL clear: tick counter, synchronizers, debounced values (0), debounce and hold counters, FSM (IDLE), PARAMS = 0, SEL = 0, DIR = 0, UPD = 0.
REQ-025 Reset asserted mid-press or mid-debounce SHALL abandon the operation; no short or long action fires after release of reset.

Structure
REQ-026 The center-FSM state encodings and the 4-bit/4-entry width constants SHALL live in a shared package rotary_pkg.
REQ-027 Synchronizer plus debouncer SHALL be one sub-module, rotary_debounce, instantiated three times and sharing the top-level tick.

Verification (SAMPLE_DIV=4, DEB_CNT=3, LONG_TICKS=8)
REQ-028 Raw A rises with B = 0 and is held for 3 ticks -> param0 = 1, UPD is a single-cycle pulse, DIR = 1.
REQ-029 A glitches high for 2 ticks only -> no step, PARAMS unchanged, UPD never asserted.
REQ-030 WRAP=1, param0 = 0, one down step -> param0 = 15; WRAP=0, same stimulus -> param0 = 0, no UPD, DIR = 0.
REQ-031 CTR held for 3 ticks, then released -> SEL 0->1 and UPD pulse; repeat 3 more times -> SEL returns to 0.
REQ-032 SEL = 2, param2 = 9, CTR held for 10 ticks -> param2 = 0 at tick 8, then no SEL change on release; a step during the hold is ignored.
REQ-033 RESETN low during HELD with PARAMS nonzero -> all outputs 0; CTR release after reset -> no SEL change.

Source files
------------

// File: rtl/rotary_pkg.sv
// -----------------------------------------------------------------------------
// rotary_pkg
// Shared types and constants for the rotary-encoder menu controller:
//   - center-button FSM state encoding
//   - parameter value width (4 bits) and parameter count (4 entries)
//   - step_value(): 4-bit up/down step with wrap or saturate behaviour
// -----------------------------------------------------------------------------
package rotary_pkg;

  localparam int VAL_W      = 4;
  localparam int NUM_PARAMS = 4;
  localparam int SEL_W      = 2;
  localparam int PARAMS_W   = VAL_W * NUM_PARAMS;

  typedef enum logic [1:0] {
    CTR_IDLE = 2'd0,
    CTR_HELD = 2'd1,
    CTR_LONG = 2'd2
  } ctr_state_t;

  // Returns {changed, new_value}. With wrap = 0 a step past 0 or 15 is
  // clamped: the value stays put and changed reads 0.
  function automatic logic [VAL_W:0] step_value(
    input logic [VAL_W-1:0] cur,
    input logic             up,
    input logic             wrap
  );
    logic [VAL_W-1:0] nxt;
    logic             changed;
    nxt     = cur;
    changed = 1'b0;
    if (up) begin
      if (!wrap && (cur == {VAL_W{1'b1}})) begin
        nxt     = cur;
        changed = 1'b0;
      end else begin
        nxt     = cur + VAL_W'(1);
        changed = 1'b1;
      end
    end else begin
      if (!wrap && (cur == {VAL_W{1'b0}})) begin
        nxt     = cur;
        changed = 1'b0;
      end else begin
        nxt     = cur - VAL_W'(1);
        changed = 1'b1;
      end
    end
    return {changed, nxt};
  endfunction

endpackage

// File: rtl/rotary_debounce.sv
// -----------------------------------------------------------------------------
// rotary_debounce
// Two-flop synchronizer followed by a tick-sampled debouncer for one raw,
// asynchronous input. The debounced level only changes after DEB_CNT
// consecutive tick samples that differ from the current level.
// Ports:
//   clk    - clock, rising edge
//   resetn - synchronous active-low reset
//   tick   - one-cycle sample strobe shared by all instances
//   raw    - asynchronous raw input
//   level  - debounced level (resets to 0)
// -----------------------------------------------------------------------------
module rotary_debounce #(
  parameter int DEB_CNT = 4
) (
  input  logic clk,
  input  logic resetn,
  input  logic tick,
  input  logic raw,
  output logic level
);

  localparam int CW = (DEB_CNT > 1) ? $clog2(DEB_CNT) : 1;

  logic          sync_1;
  logic          sync_2;
  logic [CW-1:0] cnt;

  // Synchronizer and debounce counter / stable level.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
      cnt    <= '0;
      level  <= 1'b0;
    end else begin
      sync_1 <= raw;
      sync_2 <= sync_1;
      if (tick) begin
        if (sync_2 == level) begin
          cnt <= '0;
        end else if (cnt == CW'(DEB_CNT - 1)) begin
          // This is the DEB_CNT-th differing sample in a row.
          level <= ~level;
          cnt   <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/rotary_menu_ctrl.sv
// -----------------------------------------------------------------------------
// rotary_menu_ctrl
// Rotary-encoder menu: four 4-bit parameters, one of them selected.
// Encoder steps adjust the selected parameter, a short center press moves the
// selection, a long center press clears the selected parameter.
// Ports:
//   CLK    - clock, rising edge
//   RESETN - synchronous active-low reset
//   ROTA   - raw encoder A (async)
//   ROTB   - raw encoder B (async)
//   ROTCTR - raw center push (async)
//   SEL    - index of selected parameter
//   VALUE  - value of selected parameter (combinational select of PARAMS)
//   PARAMS - param3..param0, param0 in [3:0]
//   UPD    - one-cycle pulse whenever SEL or PARAMS changes
//   DIR    - direction of the last accepted step (1 = up)
// -----------------------------------------------------------------------------
module rotary_menu_ctrl
  import rotary_pkg::*;
#(
  parameter int SAMPLE_DIV = 50000,
  parameter int DEB_CNT    = 4,
  parameter int LONG_TICKS = 1000,
  parameter int WRAP       = 1
) (
  input  logic                CLK,
  input  logic                RESETN,
  input  logic                ROTA,
  input  logic                ROTB,
  input  logic                ROTCTR,
  output logic [SEL_W-1:0]    SEL,
  output logic [VAL_W-1:0]    VALUE,
  output logic [PARAMS_W-1:0] PARAMS,
  output logic                UPD,
  output logic                DIR
);

  localparam int TW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int HW = $clog2(LONG_TICKS + 1);

  logic [TW-1:0] tick_cnt;
  logic          tick;

  logic a_lvl, b_lvl, ctr_lvl;
  logic a_prev, ctr_prev;
  logic step_evt, ctr_rise, ctr_fall;

  ctr_state_t state_r, state_nxt;
  logic [HW-1:0] hold_r, hold_nxt;

  logic [NUM_PARAMS-1:0][VAL_W-1:0] params_r, params_nxt;
  logic [SEL_W-1:0] sel_r, sel_nxt;
  logic             dir_r, dir_nxt;
  logic             upd_r, upd_nxt;
  logic [VAL_W-1:0] cur_val;
  logic [VAL_W:0]   step_res;

  assign tick = (tick_cnt == TW'(SAMPLE_DIV - 1));

  // Free-running sample-tick divider.
  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TW'(1);
    end
  end

  rotary_debounce #(.DEB_CNT(DEB_CNT)) u_deb_a (
    .clk(CLK), .resetn(RESETN), .tick(tick), .raw(ROTA), .level(a_lvl)
  );
  rotary_debounce #(.DEB_CNT(DEB_CNT)) u_deb_b (
    .clk(CLK), .resetn(RESETN), .tick(tick), .raw(ROTB), .level(b_lvl)
  );
  rotary_debounce #(.DEB_CNT(DEB_CNT)) u_deb_ctr (
    .clk(CLK), .resetn(RESETN), .tick(tick), .raw(ROTCTR), .level(ctr_lvl)
  );

  // Previous debounced levels for edge detection.
  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      a_prev   <= 1'b0;
      ctr_prev <= 1'b0;
    end else begin
      a_prev   <= a_lvl;
      ctr_prev <= ctr_lvl;
    end
  end

  assign step_evt = a_lvl & ~a_prev;
  assign ctr_rise = ctr_lvl & ~ctr_prev;
  assign ctr_fall = ~ctr_lvl & ctr_prev;

  assign cur_val  = params_r[sel_r];
  // B low at the A rising edge means clockwise (up).
  assign step_res = step_value(cur_val, ~b_lvl, (WRAP != 0));

  // Center FSM next state plus all register next values.
  always_comb begin
    state_nxt  = state_r;
    hold_nxt   = hold_r;
    params_nxt = params_r;
    sel_nxt    = sel_r;
    dir_nxt    = dir_r;
    upd_nxt    = 1'b0;
    case (state_r)
      CTR_IDLE: begin
        // A press wins over a step arriving in the same cycle.
        if (ctr_rise) begin
          state_nxt = CTR_HELD;
          hold_nxt  = '0;
        end else if (step_evt) begin
          dir_nxt           = ~b_lvl;
          params_nxt[sel_r] = step_res[VAL_W-1:0];
          upd_nxt           = step_res[VAL_W];
        end else begin
          state_nxt = CTR_IDLE;
        end
      end
      CTR_HELD: begin
        if (hold_r >= HW'(LONG_TICKS)) begin
          params_nxt[sel_r] = '0;
          upd_nxt           = (cur_val != '0);
          // A release in this very cycle must not leave us stuck in LONG.
          state_nxt         = ctr_fall ? CTR_IDLE : CTR_LONG;
        end else if (ctr_fall) begin
          sel_nxt   = sel_r + SEL_W'(1);
          upd_nxt   = 1'b1;
          state_nxt = CTR_IDLE;
        end else if (tick) begin
          hold_nxt = hold_r + HW'(1);
        end else begin
          hold_nxt = hold_r;
        end
      end
      CTR_LONG: begin
        if (ctr_fall) begin
          state_nxt = CTR_IDLE;
        end else begin
          state_nxt = CTR_LONG;
        end
      end
      default: begin
        state_nxt = CTR_IDLE;
      end
    endcase
  end

  // State, hold counter and output registers.
  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      state_r  <= CTR_IDLE;
      hold_r   <= '0;
      params_r <= '0;
      sel_r    <= '0;
      dir_r    <= 1'b0;
      upd_r    <= 1'b0;
    end else begin
      state_r  <= state_nxt;
      hold_r   <= hold_nxt;
      params_r <= params_nxt;
      sel_r    <= sel_nxt;
      dir_r    <= dir_nxt;
      upd_r    <= upd_nxt;
    end
  end

  assign SEL    = sel_r;
  assign PARAMS = params_r;
  assign VALUE  = params_r[sel_r];
  assign UPD    = upd_r;
  assign DIR    = dir_r;

endmodule

// File: tb/tb_rotary_menu_ctrl.sv
// -----------------------------------------------------------------------------
// tb_rotary_menu_ctrl
// Directed bench: two instances (WRAP=1 and WRAP=0) share the same stimulus.
// SAMPLE_DIV=4, DEB_CNT=3, LONG_TICKS=8, so one tick = 4 clocks.
// -----------------------------------------------------------------------------
module tb_rotary_menu_ctrl;

  logic CLK = 1'b0;
  logic RESETN = 1'b0;
  logic ROTA = 1'b0;
  logic ROTB = 1'b0;
  logic ROTCTR = 1'b0;

  logic [1:0]  sel_w, sel_s;
  logic [3:0]  value_w, value_s;
  logic [15:0] params_w, params_s;
  logic        upd_w, upd_s;
  logic        dir_w, dir_s;

  int checks = 0;
  int failures = 0;
  int upd_w_cnt = 0;
  int upd_s_cnt = 0;
  int snap_w;
  int snap_s;

  always #5 CLK = ~CLK;

  rotary_menu_ctrl #(.SAMPLE_DIV(4), .DEB_CNT(3), .LONG_TICKS(8), .WRAP(1)) dut_w (
    .CLK(CLK), .RESETN(RESETN), .ROTA(ROTA), .ROTB(ROTB), .ROTCTR(ROTCTR),
    .SEL(sel_w), .VALUE(value_w), .PARAMS(params_w), .UPD(upd_w), .DIR(dir_w)
  );

  rotary_menu_ctrl #(.SAMPLE_DIV(4), .DEB_CNT(3), .LONG_TICKS(8), .WRAP(0)) dut_s (
    .CLK(CLK), .RESETN(RESETN), .ROTA(ROTA), .ROTB(ROTB), .ROTCTR(ROTCTR),
    .SEL(sel_s), .VALUE(value_s), .PARAMS(params_s), .UPD(upd_s), .DIR(dir_s)
  );

  // Count UPD-high cycles, sampled away from the active edge.
  always @(negedge CLK) begin
    if (upd_w === 1'b1) upd_w_cnt <= upd_w_cnt + 1;
    if (upd_s === 1'b1) upd_s_cnt <= upd_s_cnt + 1;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic wait_ticks(input int n);
    cyc(4 * n);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    snap_w = upd_w_cnt;
    snap_s = upd_s_cnt;
  endtask

  // One full encoder detent: B set first, then an A pulse, then B back to 0.
  task automatic do_step(input logic up);
    ROTB = ~up;
    wait_ticks(6);
    ROTA = 1'b1;
    wait_ticks(6);
    ROTA = 1'b0;
    wait_ticks(6);
    ROTB = 1'b0;
    wait_ticks(6);
  endtask

  task automatic short_press();
    ROTCTR = 1'b1;
    wait_ticks(4);
    ROTCTR = 1'b0;
    wait_ticks(6);
  endtask

  // Hold well past LONG_TICKS; optionally try an up step mid-hold.
  task automatic long_press(input logic with_step);
    ROTCTR = 1'b1;
    wait_ticks(4);
    if (with_step) ROTA = 1'b1;
    wait_ticks(6);
    ROTA = 1'b0;
    wait_ticks(4);
    ROTCTR = 1'b0;
    wait_ticks(6);
  endtask

  initial begin
    // Reset state
    cyc(5);
    check("rst_params", 32'(params_w), 32'h0);
    check("rst_sel", 32'(sel_w), 32'h0);
    check("rst_value", 32'(value_w), 32'h0);
    check("rst_upd", 32'(upd_w), 32'h0);
    check("rst_dir", 32'(dir_w), 32'h0);
    RESETN = 1'b1;
    cyc(2);

    // Clean up step: param0 0 -> 1
    snap();
    ROTA = 1'b1;
    wait_ticks(6);
    check("up_params_w", 32'(params_w), 32'h0001);
    check("up_params_s", 32'(params_s), 32'h0001);
    check("up_value", 32'(value_w), 32'h1);
    check("up_dir", 32'(dir_w), 32'h1);
    check("up_upd_pulse", 32'(upd_w_cnt - snap_w), 32'd1);
    ROTA = 1'b0;
    wait_ticks(6);

    // Two-tick glitch on A: filtered out
    snap();
    ROTA = 1'b1;
    cyc(8);
    ROTA = 1'b0;
    wait_ticks(8);
    check("glitch_params", 32'(params_w), 32'h0001);
    check("glitch_upd", 32'(upd_w_cnt - snap_w), 32'd0);

    // Down to 0, then one more down: wrap to 15 vs clamp at 0
    do_step(1'b0);
    check("dn_params_w", 32'(params_w), 32'h0000);
    check("dn_dir", 32'(dir_w), 32'h0);
    snap();
    do_step(1'b0);
    check("wrap_params_w", 32'(params_w), 32'h000F);
    check("wrap_value_w", 32'(value_w), 32'hF);
    check("wrap_upd_w", 32'(upd_w_cnt - snap_w), 32'd1);
    check("clamp_params_s", 32'(params_s), 32'h0000);
    check("clamp_upd_s", 32'(upd_s_cnt - snap_s), 32'd0);
    check("clamp_dir_s", 32'(dir_s), 32'h0);

    // Short presses: SEL 1,2,3,0
    for (int i = 1; i <= 4; i++) begin
      snap();
      short_press();
      check("short_sel", 32'(sel_w), 32'(i % 4));
      check("short_upd", 32'(upd_w_cnt - snap_w), 32'd1);
    end
    check("short_params", 32'(params_w), 32'h000F);

    // Select param2 and set it to 9
    short_press();
    short_press();
    check("sel2", 32'(sel_w), 32'h2);
    for (int i = 0; i < 9; i++) do_step(1'b1);
    check("p2_params_w", 32'(params_w), 32'h090F);
    check("p2_params_s", 32'(params_s), 32'h0900);
    check("p2_value", 32'(value_w), 32'h9);

    // Long press clears param2; a step during the hold is ignored
    snap();
    long_press(1'b1);
    check("long_params_w", 32'(params_w), 32'h000F);
    check("long_params_s", 32'(params_s), 32'h0000);
    check("long_sel", 32'(sel_w), 32'h2);
    check("long_value", 32'(value_w), 32'h0);
    check("long_upd", 32'(upd_w_cnt - snap_w), 32'd1);

    // Long press on a parameter already at 0: no UPD
    snap();
    long_press(1'b0);
    check("long0_upd_w", 32'(upd_w_cnt - snap_w), 32'd0);
    check("long0_upd_s", 32'(upd_s_cnt - snap_s), 32'd0);
    check("long0_sel", 32'(sel_w), 32'h2);

    // Reset in the middle of a press
    do_step(1'b1);
    check("pre_rst_params", 32'(params_w), 32'h010F);
    ROTCTR = 1'b1;
    wait_ticks(6);
    RESETN = 1'b0;
    cyc(3);
    check("midrst_params_w", 32'(params_w), 32'h0);
    check("midrst_params_s", 32'(params_s), 32'h0);
    check("midrst_sel", 32'(sel_w), 32'h0);
    check("midrst_value", 32'(value_w), 32'h0);
    check("midrst_dir", 32'(dir_w), 32'h0);
    check("midrst_upd", 32'(upd_w), 32'h0);
    ROTCTR = 1'b0;
    cyc(4);
    RESETN = 1'b1;
    snap();
    wait_ticks(20);
    check("postrst_sel", 32'(sel_w), 32'h0);
    check("postrst_params", 32'(params_w), 32'h0);
    check("postrst_upd", 32'(upd_w_cnt - snap_w), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
